pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction-fetch sequencer for the virtual CPU: owns the program counter, runs the fetch/execute handshake with instruction memory, and sits directly upstream of the 1-bit 2x1 mux bank that forms the next-PC value. It drives the mux select with the branch decision, consumes the mux output as the next PC, and presents the fetched instruction to decode.

## Interface
- ADDR_W, 8, program counter / branch target width
- DATA_W, 8, instruction word width
- CNT_W, 16, retired-instruction counter width
- CLK  in  1  rising-edge clock
- RST  in  1  reset, synchronous, active-high
- EN  in  1  global enable; 0 = stall (all state held)
- FETCH_ACK  in  1  memory has valid INSTR this cycle
- INSTR  in  DATA_W  instruction word from memory
- BR_TAKEN  in  1  branch decision; drives next-PC mux select S
- BR_TGT  in  ADDR_W  branch target; next-PC mux input I1
- HALT  in  1  halt request from decode
- FETCH_REQ  out  1  fetch request; PC is the fetch address
- PC  out  ADDR_W  current program counter
- IR  out  DATA_W  last fetched instruction
- EXEC  out  1  high for the one execute cycle of each instruction
- HALTED  out  1  sequencer stopped
- RETIRED  out  CNT_W  instructions retired since reset

## Operation
- States: S_RESET, S_FETCH, S_EXEC, S_HALT. Moore outputs: FETCH_REQ = (state==S_FETCH), EXEC = (state==S_EXEC), HALTED = (state==S_HALT).
- RST=1 at an edge: state S_RESET, PC=0, IR=0, RETIRED=0. This overrides EN and all other inputs.
- S_RESET -> S_FETCH on the first edge with RST=0 and EN=1.
- S_FETCH: hold until FETCH_ACK=1 at an edge, then IR <= INSTR and -> S_EXEC. A FETCH_ACK received in any other state is ignored.
- S_EXEC, one cycle:
  - HALT=1: -> S_HALT. PC and RETIRED unchanged. HALT takes priority over BR_TAKEN.
  - HALT=0: PC <= mux output (BR_TAKEN ? BR_TGT : PC+1), RETIRED <= RETIRED+1, then -> S_FETCH.
- Next-PC path: ADDR_W instances of the team's 1-bit 2x1 mux, with I0 = bits of PC+1, I1 = bits of BR_TGT, and S = BR_TAKEN shared across all bits.
- PC+1 is computed modulo 2^ADDR_W: all-ones wraps to 0. RETIRED is also modulo 2^CNT_W and wraps silently.
- S_HALT is sticky. Only RST leaves it.
- EN=0: state, PC, IR and RETIRED are all held. Outputs keep their current values, so FETCH_REQ stays high if stalled in S_FETCH. Inputs sampled during the stall (ACK, BR_TAKEN, HALT) have no effect.

## Timing
- Reset values: FETCH_REQ=0, PC=0, IR=0, EXEC=0, HALTED=0, RETIRED=0.
- FETCH_REQ rises 1 cycle after reset release (given EN=1).
- Minimum instruction period is 2 cycles: ACK in the first S_FETCH cycle, then S_EXEC.
- PC update is visible the cycle after S_EXEC, which is the first cycle of the next S_FETCH, so the fetch address is always the updated PC.
- IR is valid from the S_EXEC cycle onward and is stable until the next accepted ACK.
- BR_TAKEN, BR_TGT and HALT are sampled only at the edge that ends S_EXEC.
- RST asserted mid-fetch or mid-exec: reset takes effect at that edge and the pending instruction is discarded. RETIRED is not incremented for it.

## Test plan
- Reset, then EN=1 and ACK every fetch cycle with BR_TAKEN=0 -> FETCH_REQ rises 1 cycle after release; PC steps 0,1,2,3 every 2 cycles; RETIRED=3 after 3 execute cycles.
- ADDR_W=8 with PC=8'hFF, no branch -> PC becomes 8'h00 after S_EXEC.
- In S_EXEC at PC=5, BR_TAKEN=1 and BR_TGT=8'h40 -> next FETCH_REQ cycle shows PC=8'h40; with BR_TAKEN=0 instead, PC=6.
- ACK delayed 3 cycles, and EN=0 for 2 cycles inside S_EXEC -> FETCH_REQ held high for 4 cycles; state, PC and RETIRED frozen during the stall; instruction completes normally after EN returns.
- HALT=1 together with BR_TAKEN=1 at PC=9 -> HALTED=1; PC stays 9 and RETIRED is unchanged; later ACK pulses are ignored; RST returns all outputs to zero.
- RST asserted in S_FETCH while FETCH_ACK=1 -> IR stays 0, PC=0, state S_RESET; normal fetch resumes after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the fetch/execute handshake
// with instruction memory and forms the next PC through a bank of 1-bit muxes.

module mux2x1 (
    input  logic I0,
    input  logic I1,
    input  logic S,
    output logic Y
);
    assign Y = S ? I1 : I0;
endmodule

module pc_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              FETCH_ACK,
    input  logic [DATA_W-1:0] INSTR,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_TGT,
    input  logic              HALT,
    output logic              FETCH_REQ,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic              EXEC,
    output logic              HALTED,
    output logic [CNT_W-1:0]  RETIRED,
    output logic [1:0]        dbg_state
);
    // Handshake: FETCH_REQ is held high with PC as the address for the whole
    // S_FETCH state; an instruction is accepted at the first enabled edge where
    // FETCH_REQ and FETCH_ACK are both high. ACK outside S_FETCH is ignored.

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  pc_next;

    assign pc_inc = PC + ADDR_W'(1);

    for (genvar i = 0; i < ADDR_W; i++) begin : g_next_pc
        mux2x1 u_mux (
            .I0(pc_inc[i]),
            .I1(BR_TGT[i]),
            .S (BR_TAKEN),
            .Y (pc_next[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_RESET;
            PC      <= '0;
            IR      <= '0;
            RETIRED <= '0;
        end else if (EN) begin
            state <= state_next;
            if (state == S_FETCH && FETCH_ACK) begin
                IR <= INSTR;
            end
            // HALT wins over the branch: the halting instruction does not retire.
            if (state == S_EXEC && !HALT) begin
                PC      <= pc_next;
                RETIRED <= RETIRED + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        FETCH_REQ  = 1'b0;
        EXEC       = 1'b0;
        HALTED     = 1'b0;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                FETCH_REQ = 1'b1;
                if (FETCH_ACK) state_next = S_EXEC;
            end
            S_EXEC: begin
                EXEC       = 1'b1;
                state_next = HALT ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                HALTED     = 1'b1;
                state_next = S_HALT;
            end
            default: state_next = S_RESET;
        endcase
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: scoreboard of expected fetch addresses
// plus per-scenario tasks with inline comparisons.

module tb_pc_sequencer;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              EN = 1'b0;
    logic              FETCH_ACK = 1'b0;
    logic [DATA_W-1:0] INSTR = '0;
    logic              BR_TAKEN = 1'b0;
    logic [ADDR_W-1:0] BR_TGT = '0;
    logic              HALT = 1'b0;
    logic              FETCH_REQ;
    logic [ADDR_W-1:0] PC;
    logic [DATA_W-1:0] IR;
    logic              EXEC;
    logic              HALTED;
    logic [CNT_W-1:0]  RETIRED;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] m_pc;
    logic [CNT_W-1:0]  m_ret;
    logic [DATA_W-1:0] m_ir;
    logic [ADDR_W-1:0] exp_pc;

    pc_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .FETCH_ACK(FETCH_ACK), .INSTR(INSTR),
        .BR_TAKEN(BR_TAKEN), .BR_TGT(BR_TGT), .HALT(HALT),
        .FETCH_REQ(FETCH_REQ), .PC(PC), .IR(IR), .EXEC(EXEC), .HALTED(HALTED),
        .RETIRED(RETIRED), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Drivers: inputs change and outputs are sampled 1 time unit after posedge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ack_fetch(input logic [DATA_W-1:0] instr);
        FETCH_ACK = 1'b1;
        INSTR     = instr;
        m_ir      = instr;
        tick();
        FETCH_ACK = 1'b0;
    endtask

    // Drives the execute-cycle inputs and pushes the expected next fetch address.
    task automatic exec_step(input logic br, input logic [ADDR_W-1:0] tgt, input logic halt);
        BR_TAKEN = br;
        BR_TGT   = tgt;
        HALT     = halt;
        if (!halt) begin
            m_pc  = br ? tgt : ADDR_W'(m_pc + 1);
            m_ret = m_ret + 1'b1;
            exp_q.push_back(m_pc);
        end
        tick();
        BR_TAKEN = 1'b0;
        HALT     = 1'b0;
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_ret = '0;
        m_ir  = '0;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        EN  = 1'b0;
        tick();
        tick();
        model_reset();
        checks++; if (FETCH_REQ !== 1'b0) begin errors++; $display("FAIL rst_fetch_req: got %b want 0", FETCH_REQ); end
        checks++; if (PC !== '0)          begin errors++; $display("FAIL rst_pc: got %h want 00", PC); end
        checks++; if (IR !== '0)          begin errors++; $display("FAIL rst_ir: got %h want 00", IR); end
        checks++; if (EXEC !== 1'b0)      begin errors++; $display("FAIL rst_exec: got %b want 0", EXEC); end
        checks++; if (HALTED !== 1'b0)    begin errors++; $display("FAIL rst_halted: got %b want 0", HALTED); end
        checks++; if (RETIRED !== '0)     begin errors++; $display("FAIL rst_retired: got %h want 0", RETIRED); end
        RST = 1'b0;
        EN  = 1'b1;
        checks++; if (FETCH_REQ !== 1'b0) begin errors++; $display("FAIL rel_fetch_req0: got %b want 0", FETCH_REQ); end
        tick();
        checks++; if (FETCH_REQ !== 1'b1) begin errors++; $display("FAIL rel_fetch_req1: got %b want 1", FETCH_REQ); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            exp_pc = exp_q.pop_front();
            checks++; if (PC !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", k, PC, exp_pc); end
            ack_fetch(DATA_W'($urandom_range(1, 255)));
            checks++; if (EXEC !== 1'b1 || IR !== m_ir) begin errors++; $display("FAIL seq_exec_ir[%0d]: got exec=%b ir=%h want exec=1 ir=%h", k, EXEC, IR, m_ir); end
            exec_step(1'b0, 8'h00, 1'b0);
            checks++; if (FETCH_REQ !== 1'b1) begin errors++; $display("FAIL seq_refetch[%0d]: got %b want 1", k, FETCH_REQ); end
        end
        exp_pc = exp_q.pop_front();
        checks++; if (PC !== exp_pc || PC !== 8'd3) begin errors++; $display("FAIL seq_pc_final: got %h want %h", PC, exp_pc); end
        checks++; if (RETIRED !== 16'd3) begin errors++; $display("FAIL seq_retired: got %0d want 3", RETIRED); end
    endtask

    task automatic test_wrap();
        ack_fetch(8'h11);
        exec_step(1'b1, 8'hFF, 1'b0);
        exp_pc = exp_q.pop_front();
        checks++; if (PC !== exp_pc) begin errors++; $display("FAIL wrap_to_ff: got %h want %h", PC, exp_pc); end
        ack_fetch(8'h12);
        exec_step(1'b0, 8'h55, 1'b0);
        exp_pc = exp_q.pop_front();
        checks++; if (PC !== exp_pc || PC !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h want 00", PC); end
    endtask

    task automatic test_branch();
        ack_fetch(8'h21);
        exec_step(1'b1, 8'h05, 1'b0);
        exp_pc = exp_q.pop_front();
        checks++; if (PC !== exp_pc) begin errors++; $display("FAIL br_to5: got %h want %h", PC, exp_pc); end
        ack_fetch(8'h22);
        exec_step(1'b1, 8'h40, 1'b0);
        exp_pc = exp_q.pop_front();
        checks++; if (PC !== exp_pc || FETCH_REQ !== 1'b1) begin errors++; $display("FAIL br_taken: got pc=%h req=%b want pc=%h req=1", PC, FETCH_REQ, exp_pc); end
        ack_fetch(8'h23);
        exec_step(1'b1, 8'h05, 1'b0);
        exp_pc = exp_q.pop_front();
        ack_fetch(8'h24);
        exec_step(1'b0, 8'h40, 1'b0);
        exp_pc = exp_q.pop_front();
        checks++; if (PC !== exp_pc || PC !== 8'h06) begin errors++; $display("FAIL br_not_taken: got %h want 06", PC); end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 3; c++) begin
            checks++; if (FETCH_REQ !== 1'b1) begin errors++; $display("FAIL stall_req_wait[%0d]: got %b want 1", c, FETCH_REQ); end
            tick();
        end
        checks++; if (FETCH_REQ !== 1'b1) begin errors++; $display("FAIL stall_req_ack: got %b want 1", FETCH_REQ); end
        ack_fetch(8'h5A);
        EN        = 1'b0;
        FETCH_ACK = 1'b1;
        INSTR     = 8'hEE;
        BR_TAKEN  = 1'b1;
        BR_TGT    = 8'h77;
        HALT      = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (EXEC !== 1'b1 || PC !== m_pc || RETIRED !== m_ret || IR !== m_ir) begin
                errors++;
                $display("FAIL stall_freeze[%0d]: got exec=%b pc=%h ret=%0d ir=%h want exec=1 pc=%h ret=%0d ir=%h",
                         c, EXEC, PC, RETIRED, IR, m_pc, m_ret, m_ir);
            end
        end
        EN        = 1'b1;
        FETCH_ACK = 1'b0;
        exec_step(1'b0, 8'h00, 1'b0);
        exp_pc = exp_q.pop_front();
        checks++; if (PC !== exp_pc || RETIRED !== m_ret) begin errors++; $display("FAIL stall_resume: got pc=%h ret=%0d want pc=%h ret=%0d", PC, RETIRED, exp_pc, m_ret); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            logic br;
            logic [ADDR_W-1:0] tgt;
            br  = 1'($urandom_range(0, 1));
            tgt = ADDR_W'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) tick();
            ack_fetch(DATA_W'($urandom_range(0, 255)));
            checks++; if (IR !== m_ir) begin errors++; $display("FAIL rand_ir[%0d]: got %h want %h", k, IR, m_ir); end
            exec_step(br, tgt, 1'b0);
            exp_pc = exp_q.pop_front();
            checks++; if (PC !== exp_pc) begin errors++; $display("FAIL rand_pc[%0d]: got %h want %h", k, PC, exp_pc); end
        end
        checks++; if (RETIRED !== m_ret) begin errors++; $display("FAIL rand_retired: got %0d want %0d", RETIRED, m_ret); end
    endtask

    task automatic test_halt();
        ack_fetch(8'h31);
        exec_step(1'b1, 8'h09, 1'b0);
        exp_pc = exp_q.pop_front();
        checks++; if (PC !== 8'h09) begin errors++; $display("FAIL halt_pc9: got %h want 09", PC); end
        ack_fetch(8'h32);
        exec_step(1'b1, 8'h20, 1'b1);
        checks++; if (HALTED !== 1'b1 || FETCH_REQ !== 1'b0 || EXEC !== 1'b0) begin errors++; $display("FAIL halt_flags: got halted=%b req=%b exec=%b want 1 0 0", HALTED, FETCH_REQ, EXEC); end
        checks++; if (PC !== 8'h09 || RETIRED !== m_ret) begin errors++; $display("FAIL halt_hold: got pc=%h ret=%0d want pc=09 ret=%0d", PC, RETIRED, m_ret); end
        for (int c = 0; c < 3; c++) begin
            FETCH_ACK = 1'b1;
            INSTR     = 8'hC0 + 8'(c);
            tick();
        end
        FETCH_ACK = 1'b0;
        checks++; if (HALTED !== 1'b1 || IR !== m_ir || PC !== 8'h09) begin errors++; $display("FAIL halt_sticky: got halted=%b ir=%h pc=%h want 1 %h 09", HALTED, IR, PC, m_ir); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_reset();
        checks++;
        if (FETCH_REQ !== 1'b0 || PC !== '0 || IR !== '0 || EXEC !== 1'b0 || HALTED !== 1'b0 || RETIRED !== '0) begin
            errors++;
            $display("FAIL halt_reset: got req=%b pc=%h ir=%h exec=%b halted=%b ret=%0d want all zero",
                     FETCH_REQ, PC, IR, EXEC, HALTED, RETIRED);
        end
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        ack_fetch(8'h44);
        exec_step(1'b0, 8'h00, 1'b0);
        exp_pc = exp_q.pop_front();
        FETCH_ACK = 1'b1;
        INSTR     = 8'hA5;
        RST       = 1'b1;
        tick();
        RST       = 1'b0;
        FETCH_ACK = 1'b0;
        model_reset();
        checks++; if (IR !== '0 || PC !== '0 || RETIRED !== '0) begin errors++; $display("FAIL rmf_clear: got ir=%h pc=%h ret=%0d want 0 0 0", IR, PC, RETIRED); end
        checks++; if (dbg_state !== 2'd0 || FETCH_REQ !== 1'b0) begin errors++; $display("FAIL rmf_state: got state=%0d req=%b want 0 0", dbg_state, FETCH_REQ); end
        tick();
        exp_pc = exp_q.pop_front();
        checks++; if (FETCH_REQ !== 1'b1 || PC !== exp_pc) begin errors++; $display("FAIL rmf_resume: got req=%b pc=%h want 1 %h", FETCH_REQ, PC, exp_pc); end
        ack_fetch(8'h3C);
        checks++; if (IR !== 8'h3C) begin errors++; $display("FAIL rmf_ir: got %h want 3c", IR); end
        exec_step(1'b0, 8'h00, 1'b0);
        exp_pc = exp_q.pop_front();
        checks++; if (PC !== exp_pc || RETIRED !== 16'd1) begin errors++; $display("FAIL rmf_done: got pc=%h ret=%0d want %h 1", PC, RETIRED, exp_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_branch();
        test_stall();
        test_random();
        test_halt();
        test_reset_mid_fetch();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d want 0 entries", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
